// File: rtl/stack_program_loader.sv
// Byte-serial loader: parses a framed program image, writes 12-bit words into
// the stack machine's instruction memory, zero-fills the rest and gates its reset.
module stack_program_loader #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         DEPTH  = 32,
  parameter int         AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [11:0]   imem_wdata,
  output logic          cpu_rstN,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_OPC   = 3'd2,
    S_VAL   = 3'd3,
    S_SUM   = 3'd4,
    S_FILL  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  // N and the index carry one extra bit so that a full image (N = DEPTH) fits.
  localparam logic [AW:0] DEPTH_IDX = DEPTH[AW:0];
  localparam logic [8:0]  DEPTH_N   = DEPTH[8:0];
  localparam logic [AW:0] IDX_ONE   = {{AW{1'b0}}, 1'b1};

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    opc_q, opc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [11:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cpu_rstn_q, cpu_rstn_d;
  logic          accept;
  logic [AW:0]   idx_inc;

  assign accept  = in_valid && ready_q;
  assign idx_inc = idx_q + IDX_ONE;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      sum_q      <= 8'h00;
      opc_q      <= 4'h0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 12'h000;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      opc_q      <= opc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_rstn_q <= cpu_rstn_d;
    end
  end

  // Frame parser: next state plus index/sum bookkeeping and write issue.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    opc_d   = opc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && (in_data == HEADER)) begin
          state_d = S_COUNT;
        end else begin
          state_d = state_q;
        end
      end
      S_COUNT: begin
        if (!accept) begin
          state_d = state_q;
        end else if ((in_data == 8'h00) || ({1'b0, in_data} > DEPTH_N)) begin
          state_d = S_ERROR;
        end else begin
          n_d     = in_data[AW:0];
          idx_d   = '0;
          sum_d   = 8'h00;
          state_d = S_OPC;
        end
      end
      S_OPC: begin
        if (!accept) begin
          state_d = state_q;
        end else if (in_data > 8'h07) begin
          state_d = S_ERROR;
        end else begin
          opc_d   = {1'b0, in_data[2:0]};
          sum_d   = sum8(sum_q, in_data);
          state_d = S_VAL;
        end
      end
      S_VAL: begin
        if (accept) begin
          sum_d   = sum8(sum_q, in_data);
          we_d    = 1'b1;
          addr_d  = idx_q[AW-1:0];
          wdata_d = {opc_q, in_data};
          idx_d   = idx_inc;
          state_d = (idx_inc == n_q) ? S_SUM : S_OPC;
        end else begin
          state_d = state_q;
        end
      end
      S_SUM: begin
        if (!accept) begin
          state_d = state_q;
        end else if (in_data != sum_q) begin
          state_d = S_ERROR;
        end else if (n_q == DEPTH_IDX) begin
          state_d = S_DONE;
        end else begin
          // First fill word goes out with the checksum; idx then tracks the next address.
          we_d    = 1'b1;
          addr_d  = n_q[AW-1:0];
          wdata_d = 12'h000;
          idx_d   = n_q + IDX_ONE;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (idx_q == DEPTH_IDX) begin
          state_d = S_DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = idx_q[AW-1:0];
          wdata_d = 12'h000;
          idx_d   = idx_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs follow the state being entered so they register with it.
  always_comb begin
    ready_d    = (state_d != S_FILL);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
    cpu_rstn_d = (state_d == S_DONE);
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rstN   = cpu_rstn_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
